// File: rtl/reset_seq_pkg.sv
// +--------------------------------------------------------------------+
// | reset_seq_pkg : shared state encoding and default widths            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } seqState_t;

  localparam int DEFAULT_DELAY_BITS    = 8;
  localparam int DEFAULT_DEBOUNCE_BITS = 16;
  localparam int DEFAULT_SYNC_STAGES   = 2;

endpackage

`default_nettype wire

// File: rtl/reset_seq_debounce.sv
// +--------------------------------------------------------------------+
// | debounce : button synchronizer, stability counter, level and press  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_BITS = DEFAULT_DEBOUNCE_BITS,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iButton,
  output logic oLevel,
  output logic oPress
);

  localparam logic [DEBOUNCE_BITS-1:0] c_cntOne = DEBOUNCE_BITS'(1);

  logic [SYNC_STAGES-1:0]   r_sync;
  logic [DEBOUNCE_BITS-1:0] r_count;
  logic                     r_level;
  logic                     r_press;
  logic                     w_differs;

  assign w_differs = r_sync[SYNC_STAGES-1] ^ r_level;
  assign oLevel    = r_level;
  assign oPress    = r_press;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_sync  <= '0;
      r_count <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], iButton};
      r_press <= 1'b0;
      if (!w_differs) begin
        r_count <= '0;
      end else if (&r_count) begin
        // Pulse only when the level flips high; a release is silent.
        r_level <= ~r_level;
        r_press <= ~r_level;
        r_count <= '0;
      end else begin
        r_count <= r_count + c_cntOne;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reset_seq.sv
// +--------------------------------------------------------------------+
// | reset_seq : staged per-domain reset release after PLL lock          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int STAGES        = 3,
  parameter int DELAY_BITS    = DEFAULT_DELAY_BITS,
  parameter int DEBOUNCE_BITS = DEFAULT_DEBOUNCE_BITS,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iLocked,
  input  logic              iButton,
  output logic [STAGES-1:0] oReset,
  output logic              oReady
);

  localparam int c_idxW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [c_idxW-1:0]     c_lastIdx = c_idxW'(STAGES - 1);
  localparam logic [c_idxW-1:0]     c_idxOne  = c_idxW'(1);
  localparam logic [DELAY_BITS-1:0] c_gapLast = '1;
  localparam logic [DELAY_BITS-1:0] c_gapOne  = DELAY_BITS'(1);

  logic [SYNC_STAGES-1:0] r_lockSync;
  seqState_t              r_state;
  logic [DELAY_BITS-1:0]  r_gapCnt;
  logic [c_idxW-1:0]      r_idx;
  logic [STAGES-1:0]      r_reset;
  logic                   r_ready;
  logic                   w_locked;
  logic                   w_btnLevel;
  logic                   w_btnPress;
  logic                   w_abort;

  debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_debounce (
    .iClk   (iClk),
    .iReset (iReset),
    .iButton(iButton),
    .oLevel (w_btnLevel),
    .oPress (w_btnPress)
  );

  assign w_locked = r_lockSync[SYNC_STAGES-1];
  assign w_abort  = !w_locked || (w_btnPress && w_btnLevel);
  assign oReset   = r_reset;
  assign oReady   = r_ready;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_lockSync <= '0;
      r_state    <= WAIT_LOCK;
      r_gapCnt   <= '0;
      r_idx      <= '0;
      r_reset    <= '1;
      r_ready    <= 1'b0;
    end else begin
      r_lockSync <= {r_lockSync[SYNC_STAGES-2:0], iLocked};
      // Abort wins over any release due on the same edge.
      if (w_abort) begin
        r_state  <= WAIT_LOCK;
        r_gapCnt <= '0;
        r_idx    <= '0;
        r_reset  <= '1;
        r_ready  <= 1'b0;
      end else begin
        case (r_state)
          WAIT_LOCK: begin
            r_reset  <= '1;
            r_ready  <= 1'b0;
            r_gapCnt <= '0;
            r_idx    <= '0;
            if (w_locked) r_state <= RELEASE;
          end
          RELEASE: begin
            if (r_gapCnt == c_gapLast) begin
              r_reset[r_idx] <= 1'b0;
              r_gapCnt       <= '0;
              r_idx          <= r_idx + c_idxOne;
              if (r_idx == c_lastIdx) begin
                r_state <= RUN;
                r_ready <= 1'b1;
              end
            end else begin
              r_gapCnt <= r_gapCnt + c_gapOne;
            end
          end
          RUN: begin
            r_reset <= '0;
            r_ready <= 1'b1;
          end
          default: r_state <= WAIT_LOCK;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reset_seq.sv
// +--------------------------------------------------------------------+
// | tb_reset_seq : self-checking bench for reset_seq (D=4, window=8)    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_reset_seq;

  logic       iClk;
  logic       iReset;
  logic       iLocked;
  logic       iButton;
  logic [2:0] oReset;
  logic       oReady;

  reset_seq #(
    .STAGES       (3),
    .DELAY_BITS   (2),
    .DEBOUNCE_BITS(3),
    .SYNC_STAGES  (2)
  ) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .iLocked(iLocked),
    .iButton(iButton),
    .oReset (oReset),
    .oReady (oReady)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       btn;
    logic [2:0] expReset;
    logic       expReady;
  } vec_t;

  typedef struct {
    logic [2:0] expReset;
    logic       expReady;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Expected outputs e edges after the lock (as seen by the synchronizer) rises.
  function automatic logic [3:0] seqExp(input int e);
    logic [2:0] r;
    r = 3'b111;
    if (e >= 7)  r[0] = 1'b0;
    if (e >= 11) r[1] = 1'b0;
    if (e >= 15) r[2] = 1'b0;
    return {(e >= 15), r};
  endfunction

  task automatic checkOut();
    exp_t e;
    e = sb.pop_front();
    nChecks++;
    if (oReset !== e.expReset || oReady !== e.expReady) begin
      nFails++;
      $display("FAIL %s @%0t: oReset=%b oReady=%b, expected oReset=%b oReady=%b",
               e.name, $time, oReset, oReady, e.expReset, e.expReady);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic b,
                      input logic [2:0] er, input logic erdy, input string nm);
    exp_t e;
    iReset  = r;
    iLocked = l;
    iButton = b;
    e.expReset = er;
    e.expReady = erdy;
    e.name     = nm;
    sb.push_back(e);
    @(posedge iClk);
    #1;
    checkOut();
  endtask

  task automatic stepSeq(input logic l, input logic b, input int e, input string nm);
    logic [3:0] x;
    x = seqExp(e);
    step(1'b0, l, b, x[2:0], x[3], nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[25];
    logic [3:0] x;
    exp_t ae;

    for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0};
    for (int i = 5; i < 25; i++) begin
      x = seqExp(i - 4);
      vecs[i] = '{1'b0, 1'b1, 1'b0, x[2:0], x[3]};
    end

    iReset  = 1'b1;
    iLocked = 1'b1;
    iButton = 1'b0;

    // Power-up
    for (int i = 0; i < 25; i++)
      step(vecs[i].rst, vecs[i].lock, vecs[i].btn, vecs[i].expReset, vecs[i].expReady,
           (i < 5) ? "powerup_reset" : "powerup_seq");

    // Lock loss in RUN, then late lock after 20 low cycles
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "lockloss_run_hold");
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "lockloss_run_hold");
    for (int i = 3; i <= 20; i++) step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, "lockloss_run_abort");
    for (int e = 1; e <= 20; e++) stepSeq(1'b1, 1'b0, e, "late_lock_seq");

    // Lock loss mid-RELEASE: abort lands on the edge bit 1 would clear
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "lockloss2_hold");
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "lockloss2_hold");
    step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, "lockloss2_abort");
    step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, "lockloss2_abort");
    for (int e = 1; e <= 8; e++) stepSeq(1'b1, 1'b0, e, "midrel_seq");
    step(1'b0, 1'b0, 1'b0, 3'b110, 1'b0, "midrel_drop");
    step(1'b0, 1'b0, 1'b0, 3'b110, 1'b0, "midrel_drop");
    step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, "midrel_abort_priority");
    step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, "midrel_abort_hold");

    // Back to RUN, then bouncy button
    for (int e = 1; e <= 16; e++) stepSeq(1'b1, 1'b0, e, "relock_seq");
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, "bounce_high");
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "bounce_low");
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "bounce_settle");

    // Held press aborts on edge 11, then resequences with the button still held
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, "press_window");
    for (int k = 11; k <= 30; k++) stepSeq(1'b1, 1'b1, k - 9, "press_abort_reseq");

    // Lock drop and re-lock while button still held: no extra abort
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b1, "held_lockloss_hold");
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b1, "held_lockloss_hold");
    for (int i = 3; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, "held_lockloss_abort");
    for (int e = 1; e <= 20; e++) stepSeq(1'b1, 1'b1, e, "held_relock_seq");

    // Button release never aborts
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "release_no_abort");

    // Async reset mid-RELEASE
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "pre_async_hold");
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "pre_async_hold");
    step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, "pre_async_abort");
    step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, "pre_async_abort");
    for (int e = 1; e <= 8; e++) stepSeq(1'b1, 1'b0, e, "pre_async_seq");
    iReset = 1'b1;
    ae.expReset = 3'b111;
    ae.expReady = 1'b0;
    ae.name     = "async_reset_immediate";
    sb.push_back(ae);
    #2;
    checkOut();
    iReset = 1'b0;
    #1;
    for (int e = 1; e <= 16; e++) stepSeq(1'b1, 1'b0, e, "post_async_seq");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
